// File: rtl/frontend_command_definition_pkg.sv
// rtl/frontend_command_definition_pkg.sv - frontend command types and arbiter constants
package frontend_command_definition_pkg;

    localparam int CORE_NUM_W = 4;
    localparam int REQ_ID_W   = 8;
    localparam int ADDR_W     = 32;

    localparam int NUM_CORES_DEFAULT       = 4;
    localparam int BEATS_PER_WRITE_DEFAULT = 4;
    localparam int WORD_SIZE_DEFAULT       = 256;

    typedef logic [CORE_NUM_W-1:0] core_num_t;
    typedef logic [REQ_ID_W-1:0]   req_id_t;
    typedef logic [1:0]            op_t;

    localparam op_t OP_READ  = 2'd0;
    localparam op_t OP_WRITE = 2'd1;

    typedef struct packed {
        op_t               op;
        core_num_t         core_num;
        req_id_t           req_id;
        logic [ADDR_W-1:0] addr;
    } frontend_command_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Anything that is not a write is treated as a single-beat request.
    function automatic logic is_write_op(op_t op);
        return op == OP_WRITE;
    endfunction

endpackage

// File: rtl/core_request_arbiter_if.sv
// rtl/core_request_arbiter_if.sv - core-side and scheduler-side signals of the request arbiter
interface core_request_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int WORD_SIZE = 256
) ();
    import frontend_command_definition_pkg::*;

    logic [NUM_CORES-1:0]                i_core_request_valid;
    frontend_command_t [NUM_CORES-1:0]   i_core_request;
    logic [NUM_CORES-1:0][WORD_SIZE-1:0] i_core_write_data;
    logic [NUM_CORES-1:0]                i_core_write_data_last;
    logic [NUM_CORES-1:0]                o_core_ready;
    logic                                i_scheduler_ready;
    logic                                o_request_valid;
    frontend_command_t                   o_request;
    logic [WORD_SIZE-1:0]                o_write_data;
    logic                                o_write_data_last;
    logic [NUM_CORES-1:0]                o_grant;
    logic                                o_protocol_error;

    // Arbiter side
    modport slave (
        input  i_core_request_valid, i_core_request, i_core_write_data,
               i_core_write_data_last, i_scheduler_ready,
        output o_core_ready, o_request_valid, o_request, o_write_data,
               o_write_data_last, o_grant, o_protocol_error
    );

    // Cores plus scheduler side
    modport master (
        output i_core_request_valid, i_core_request, i_core_write_data,
               i_core_write_data_last, i_scheduler_ready,
        input  o_core_ready, o_request_valid, o_request, o_write_data,
               o_write_data_last, o_grant, o_protocol_error
    );

endinterface

// File: rtl/core_request_arbiter_rr_priority_picker.sv
// rtl/core_request_arbiter_rr_priority_picker.sv - first valid requester at or after rr_ptr, with wrap
module rr_priority_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] valid_vec,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest valid core after rr_ptr is the one left standing
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            cand = rr_ptr + IDX_W'(i);
            if (valid_vec[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_request_arbiter.sv
// rtl/core_request_arbiter.sv - round-robin share of the scheduler request port with write-burst lock
module core_request_arbiter
    import frontend_command_definition_pkg::*;
#(
    parameter int NUM_CORES       = NUM_CORES_DEFAULT,
    parameter int BEATS_PER_WRITE = BEATS_PER_WRITE_DEFAULT,
    parameter int WORD_SIZE       = WORD_SIZE_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    core_request_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CNT_W = $clog2(BEATS_PER_WRITE) + 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   locked_q, locked_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;

    logic [NUM_CORES-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [NUM_CORES-1:0] gnt_vec;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_any;
    frontend_command_t    gnt_cmd;

    logic xfer;
    logic beat_is_final;
    logic burst_op;
    logic beat_last;

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .valid_vec (bus.i_core_request_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Grant source: free round-robin pick in IDLE, the locked core for the rest of a write burst
    always_comb begin
        gnt_idx = pick_idx;
        gnt_any = pick_any;
        gnt_vec = pick_grant;
        if (state_q == BURST) begin
            gnt_idx           = locked_q;
            gnt_any           = 1'b1;
            gnt_vec           = '0;
            gnt_vec[locked_q] = 1'b1;
        end
    end

    // Zero-cycle pass-through of the granted core; everything is held at zero while reset is asserted
    always_comb begin
        gnt_cmd          = bus.i_core_request[gnt_idx];
        gnt_cmd.core_num = core_num_t'(gnt_idx);

        bus.o_grant           = '0;
        bus.o_core_ready      = '0;
        bus.o_request_valid   = 1'b0;
        bus.o_request         = '0;
        bus.o_write_data      = '0;
        bus.o_write_data_last = 1'b0;
        bus.o_protocol_error  = 1'b0;
        if (i_rst_n) begin
            bus.o_protocol_error = err_q;
            if (gnt_any) begin
                bus.o_grant           = gnt_vec;
                bus.o_core_ready      = bus.i_scheduler_ready ? gnt_vec : '0;
                bus.o_request_valid   = bus.i_core_request_valid[gnt_idx];
                bus.o_request         = gnt_cmd;
                bus.o_write_data      = bus.i_core_write_data[gnt_idx];
                bus.o_write_data_last = bus.i_core_write_data_last[gnt_idx];
            end
        end
    end

    // Next state: reads rotate immediately, writes lock until the final or an early-last beat
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        xfer          = bus.o_request_valid && bus.i_scheduler_ready;
        beat_is_final = (state_q == BURST) ? (beat_cnt_q == CNT_W'(BEATS_PER_WRITE - 1))
                                           : (BEATS_PER_WRITE == 1);
        burst_op      = (state_q == BURST) || is_write_op(bus.i_core_request[gnt_idx].op);
        beat_last     = bus.i_core_write_data_last[gnt_idx];

        if (xfer) begin
            if (!burst_op) begin
                rr_ptr_d = gnt_idx + IDX_W'(1);
            end else if (beat_last || beat_is_final) begin
                // A last marker that disagrees with the beat count still closes the burst
                if (beat_last != beat_is_final) begin
                    err_d = 1'b1;
                end
                state_d    = IDLE;
                rr_ptr_d   = gnt_idx + IDX_W'(1);
                beat_cnt_d = '0;
            end else begin
                state_d    = BURST;
                locked_d   = gnt_idx;
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            locked_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: doc/core_request_arbiter.md
Name: core_request_arbiter

Overview:
- Shares the frontend_scheduler request/write-data port between NUM_CORES core-side requesters using round-robin arbitration.
- Sits between the per-core interconnection ports and the scheduler's i_interconnection_* inputs.
- Read requests are single-beat. Write requests lock the grant until BEATS_PER_WRITE data beats (256-bit each, forming one 1024-bit backend word) have transferred.
- Stamps the granted core index into the command's core_num field and flags burst protocol violations.

Parameters:
- NUM_CORES, 4, number of requesting cores (power of 2, >=2).
- BEATS_PER_WRITE, 4, 256-bit write beats per write request.
- WORD_SIZE, 256, frontend write-data width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_core_request_valid  in  NUM_CORES  per-core request/beat valid.
- i_core_request  in  NUM_CORES x frontend_command_t  per-core command; read when beat 0 is presented.
- i_core_write_data  in  NUM_CORES x WORD_SIZE  per-core write beat.
- i_core_write_data_last  in  NUM_CORES  per-core last-beat marker.
- o_core_ready  out  NUM_CORES  one-hot ready; only the granted core can be high.
- i_scheduler_ready  in  1  frontend_scheduler o_scheduler_ready.
- o_request_valid  out  1  to i_interconnection_request_valid.
- o_request  out  frontend_command_t  granted command, core_num overwritten with the grant index.
- o_write_data  out  WORD_SIZE  granted write beat.
- o_write_data_last  out  1  granted last marker.
- o_grant  out  NUM_CORES  one-hot current grant (debug/perf).
- o_protocol_error  out  1  sticky burst-violation flag.

Behaviour:
- Reset (synchronous, i_rst_n=0 at posedge): state=IDLE, rr_ptr=0, beat_cnt=0, o_protocol_error=0, locked grant cleared. All outputs are combinationally 0 while in IDLE with no valid request.
- Handshake: a beat transfers on o_request_valid && i_scheduler_ready.
- o_core_ready[g] = i_scheduler_ready && granted(g). Zero-cycle pass-through: o_request_valid, o_request, o_write_data and o_write_data_last are muxed from the granted core in the same cycle.
- IDLE:
  - The grant is chosen combinationally: the first valid core searching from rr_ptr upward, with wrap-around.
  - If the granted command is a read and it transfers: rr_ptr <= g+1 (mod NUM_CORES); stay in IDLE.
  - If it is a write and beat 0 transfers: lock g, beat_cnt <= 1, go to BURST. If BEATS_PER_WRITE==1 and last is set, complete as for a read instead.
  - If it is not accepted (ready low), the grant is not locked. It is re-evaluated next cycle, but rr_ptr holds, so the same core keeps priority while still valid.
- BURST:
  - Grant is fixed to the locked core; other cores see ready=0.
  - Each transfer increments beat_cnt.
  - On the transfer where beat_cnt==BEATS_PER_WRITE-1: last must be 1. Return to IDLE, rr_ptr <= locked+1, beat_cnt <= 0.
  - The valid of the locked core may drop between beats (bubbles allowed); the grant is held indefinitely.
- Protocol error (sticky until reset), triggered by either:
  - last=1 on a transfer before the final beat: treat the burst as ended, go to IDLE, rotate rr_ptr.
  - last=0 on the final beat: still end the burst and return to IDLE.
- o_request in BURST mirrors the locked core's i_core_request; the scheduler only samples it on beat 0.
- Simultaneous valids: exactly one grant; lowest index at or after rr_ptr wins.
- Reset mid-burst: burst abandoned, state IDLE next cycle, no outputs asserted during reset.
- Every valid core is served within NUM_CORES transactions; no starvation.

Decomposition:
- Shared package frontend_command_definition_pkg (existing) supplies frontend_command_t, core_num_t, req_id_t. Add there: the op-type encoding constants if not already present, BEATS_PER_WRITE_DEFAULT, and arb_state_t {IDLE, BURST}.
- One sub-module: rr_priority_picker. Purely combinational; takes valid vector and rr_ptr, returns one-hot grant plus index.

Test Plan:
- Single core 2 issues a read, scheduler ready=1 -> same-cycle o_request_valid=1, o_request.core_num=2, o_core_ready=4'b0100, rr_ptr becomes 3.
- All four cores valid with reads, rr_ptr=0, ready=1 -> grant order 0,1,2,3,0 on consecutive cycles.
- Core 1 write (4 beats, data 0xA..0xD) while core 0 is also valid; stall ready on beat 2 and drop core 1 valid for one cycle -> all four beats come from core 1 in order, last on beat 4, core 0 granted on the next cycle.
- Core 3 write asserts last on beat 2 -> o_protocol_error=1 (stays 1), state IDLE, rr_ptr=0.
- Reset asserted after beat 1 of a core 0 write -> next cycle o_grant=0, o_request_valid=0. After release, a core 1 read is granted with rr_ptr=0 search.
- Ready held low for 10 cycles with cores 0 and 2 valid, rr_ptr=0 -> core 0 stays granted, nothing transfers, rr_ptr unchanged. When ready rises, core 0 transfers first.
